// File: rtl/cache_sa_wb_lru.sv
// N-way set-associative cache tag/statistics model with write-back dirty tracking,
// LRU or FIFO replacement, valid/ready request handshake and saturating counters.
module cache_sa_wb_lru #(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 32768,
    parameter int ADDR_W          = 32,
    parameter int POLICY          = 0,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic              prefetch_hit,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_evict_dirty,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  wb_count,
    output logic              init_done
);

    localparam int SET    = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY);
    localparam int OFF_W  = $clog2(BLOCK_SIZE_BYTE);
    localparam int IDX_W  = $clog2(SET);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W  = $clog2(WAY);
    localparam int LINE_W = TAG_W + 2;

    localparam logic [WAY_W-1:0] WAY_ZERO = {WAY_W{1'b0}};
    localparam logic [WAY_W-1:0] WAY_ONE  = WAY_W'(1);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAY - 1);
    localparam logic [IDX_W-1:0] SET_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SET - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_PF,
        S_UPDATE,
        S_RESP
    } state_t;

    // Line layout: {valid, dirty, tag}; way 0 is the newest entry of a set.
    logic [LINE_W-1:0] line_r [WAY][SET];

    state_t            state_r;
    logic [IDX_W-1:0]  init_idx_r;
    logic [IDX_W-1:0]  set_r;
    logic [TAG_W-1:0]  tag_r;
    logic              write_r;
    logic [WAY_W-1:0]  way_r;
    logic [WAY_W-1:0]  step_r;
    logic [WAY_W-1:0]  wr_way_r;
    logic              hit_flag_r;
    logic              evict_flag_r;
    logic              hit_dirty_r;

    logic [LINE_W-1:0] cur_line_s;
    logic [LINE_W-1:0] victim_line_s;
    logic              cur_match_s;
    logic              victim_dirty_s;
    logic [LINE_W-1:0] new_line_s;
    logic              unused_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + CNT_W'(1);
        end
    endfunction

    assign cur_line_s     = line_r[way_r][set_r];
    assign victim_line_s  = line_r[LAST_WAY][set_r];
    assign cur_match_s    = cur_line_s[LINE_W-1] && (cur_line_s[TAG_W-1:0] == tag_r);
    assign victim_dirty_s = victim_line_s[LINE_W-1] && victim_line_s[LINE_W-2];
    assign new_line_s     = {1'b1, hit_dirty_r | write_r, tag_r};
    assign unused_s       = ^req_addr[OFF_W-1:0];

    // Tag array: one set cleared per INIT cycle; UPDATE shifts toward the victim, then installs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            case (state_r)
                S_INIT: begin
                    for (int w = 0; w < WAY; w++) begin
                        line_r[w[WAY_W-1:0]][init_idx_r] <= {LINE_W{1'b0}};
                    end
                end
                S_UPDATE: begin
                    if (step_r != WAY_ZERO) begin
                        line_r[step_r][set_r] <= line_r[step_r - WAY_ONE][set_r];
                    end else begin
                        line_r[wr_way_r][set_r] <= new_line_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control FSM, statistics counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= S_INIT;
            init_idx_r       <= {IDX_W{1'b0}};
            set_r            <= {IDX_W{1'b0}};
            tag_r            <= {TAG_W{1'b0}};
            write_r          <= 1'b0;
            way_r            <= WAY_ZERO;
            step_r           <= WAY_ZERO;
            wr_way_r         <= WAY_ZERO;
            hit_flag_r       <= 1'b0;
            evict_flag_r     <= 1'b0;
            hit_dirty_r      <= 1'b0;
            req_ready        <= 1'b0;
            resp_valid       <= 1'b0;
            resp_hit         <= 1'b0;
            resp_evict_dirty <= 1'b0;
            hit_count        <= {CNT_W{1'b0}};
            miss_count       <= {CNT_W{1'b0}};
            wb_count         <= {CNT_W{1'b0}};
            init_done        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state_r)
                S_INIT: begin
                    init_idx_r <= init_idx_r + SET_ONE;
                    if (init_idx_r == LAST_SET) begin
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                        state_r   <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        set_r            <= req_addr[OFF_W +: IDX_W];
                        tag_r            <= req_addr[ADDR_W-1 -: TAG_W];
                        write_r          <= req_write;
                        way_r            <= WAY_ZERO;
                        hit_flag_r       <= 1'b0;
                        evict_flag_r     <= 1'b0;
                        hit_dirty_r      <= 1'b0;
                        resp_hit         <= 1'b0;
                        resp_evict_dirty <= 1'b0;
                        req_ready        <= 1'b0;
                        state_r          <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (cur_match_s) begin
                        hit_count   <= sat_inc(hit_count);
                        hit_flag_r  <= 1'b1;
                        hit_dirty_r <= cur_line_s[LINE_W-2];
                        // LRU bubbles the hit line to way 0; FIFO rewrites it in place.
                        step_r      <= (POLICY == 0) ? way_r : WAY_ZERO;
                        wr_way_r    <= (POLICY == 0) ? WAY_ZERO : way_r;
                        state_r     <= S_UPDATE;
                    end else if (way_r == LAST_WAY) begin
                        state_r <= S_PF;
                    end else begin
                        way_r <= way_r + WAY_ONE;
                    end
                end
                S_PF: begin
                    if (prefetch_hit) begin
                        hit_count  <= sat_inc(hit_count);
                        hit_flag_r <= 1'b1;
                    end else begin
                        miss_count <= sat_inc(miss_count);
                    end
                    // The victim must be inspected before the first shift overwrites it.
                    if (victim_dirty_s) begin
                        wb_count     <= sat_inc(wb_count);
                        evict_flag_r <= 1'b1;
                    end
                    step_r   <= LAST_WAY;
                    wr_way_r <= WAY_ZERO;
                    state_r  <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (step_r != WAY_ZERO) begin
                        step_r <= step_r - WAY_ONE;
                    end else begin
                        state_r <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid       <= 1'b1;
                    resp_hit         <= hit_flag_r;
                    resp_evict_dirty <= evict_flag_r;
                    req_ready        <= 1'b1;
                    state_r          <= S_IDLE;
                end
                default: begin
                    state_r <= S_INIT;
                end
            endcase
        end
    end

endmodule
